// File: rtl/ysyx_2022040010_inst_fetch_arb_pkg.sv
// Shared types and constants for the instruction-fetch arbiter and its starvation counter.
// Bus widths and ROM enable/zero encodings mirror the core's global defines.
package ysyx_2022040010_inst_fetch_arb_pkg;

    localparam int INST_ADDR_W      = 64;
    localparam int INST_W_DEF       = 32;
    localparam int MAX_CORE_RUN_DEF = 4;

    localparam logic        ChipEnable  = 1'b1;
    localparam logic        ChipDisable = 1'b0;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_e;

    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return addr_lsb != 2'b00;
    endfunction

endpackage

// File: rtl/ysyx_2022040010_rr_starve_cnt.sv
// Grant decision between core (0) and debug (1) requesters; combinational grant, registered run counter.
// The core wins ties until it has taken MAX_CORE_RUN grants in a row while the debug port waited.
module ysyx_2022040010_rr_starve_cnt
    import ysyx_2022040010_inst_fetch_arb_pkg::*;
#(
    parameter int MAX_CORE_RUN = MAX_CORE_RUN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_accept,
    input  logic       i_m0_vld,
    input  logic       i_m1_vld,
    output logic       o_grant,
    output logic [3:0] o_run_cnt
);

    localparam logic [3:0] RUN_MAX = 4'(MAX_CORE_RUN);

    logic [3:0] r_run_cnt;

    always_comb begin
        o_grant = i_m1_vld;
        if (i_m0_vld && i_m1_vld) begin
            o_grant = (r_run_cnt == RUN_MAX);
        end
    end

    // Counter only measures streaks during which the debug port is actually waiting.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run_cnt <= 4'd0;
        end else if (!i_m1_vld || (i_accept && o_grant)) begin
            r_run_cnt <= 4'd0;
        end else if (i_accept && (r_run_cnt != RUN_MAX)) begin
            r_run_cnt <= r_run_cnt + 4'd1;
        end
    end

    assign o_run_cnt = r_run_cnt;

endmodule

// File: rtl/ysyx_2022040010_inst_fetch_arb.sv
// Arbitrates the combinational instruction ROM between IF (m0) and debug (m1); response one cycle after accept.
// A held response blocks new accepts until its owner takes it; completion and next accept may share a cycle.
module ysyx_2022040010_inst_fetch_arb
    import ysyx_2022040010_inst_fetch_arb_pkg::*;
#(
    parameter int ADDR_W       = INST_ADDR_W,
    parameter int INST_W       = INST_W_DEF,
    parameter int MAX_CORE_RUN = MAX_CORE_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    input  logic [ADDR_W-1:0] m0_req_addr,
    output logic              m0_req_ready,
    output logic              m0_rsp_valid,
    output logic [INST_W-1:0] m0_rsp_inst,
    output logic              m0_rsp_err,
    input  logic              m0_rsp_ready,
    input  logic              m1_req_valid,
    input  logic [ADDR_W-1:0] m1_req_addr,
    output logic              m1_req_ready,
    output logic              m1_rsp_valid,
    output logic [INST_W-1:0] m1_rsp_inst,
    output logic              m1_rsp_err,
    input  logic              m1_rsp_ready,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst
);

    arb_state_e        r_state;
    logic              r_owner;
    logic [INST_W-1:0] r_rsp_inst;
    logic              r_rsp_err;
    logic [ADDR_W-1:0] r_rom_addr;

    logic              w_owner_rdy;
    logic              w_can_accept;
    logic              w_accept;
    logic              w_grant;
    logic [ADDR_W-1:0] w_win_addr;
    logic              w_win_mis;
    logic [3:0]        w_run_cnt;

    assign w_owner_rdy  = r_owner ? m1_rsp_ready : m0_rsp_ready;
    assign w_can_accept = (r_state == ARB_IDLE) || w_owner_rdy;
    // Qualified with rst so the ROM port reads disabled/zero while reset is held.
    assign w_accept     = rst && w_can_accept && (m0_req_valid || m1_req_valid);

    ysyx_2022040010_rr_starve_cnt #(
        .MAX_CORE_RUN (MAX_CORE_RUN)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .i_accept  (w_accept),
        .i_m0_vld  (m0_req_valid),
        .i_m1_vld  (m1_req_valid),
        .o_grant   (w_grant),
        .o_run_cnt (w_run_cnt)
    );

    assign w_win_addr = w_grant ? m1_req_addr : m0_req_addr;
    assign w_win_mis  = is_misaligned(w_win_addr[1:0]);

    assign m0_req_ready = w_accept && !w_grant;
    assign m1_req_ready = w_accept && w_grant;

    assign rom_ce   = (w_accept && !w_win_mis) ? ChipEnable : ChipDisable;
    assign rom_addr = w_accept ? w_win_addr : r_rom_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ARB_IDLE;
            r_owner    <= 1'b0;
            r_rsp_inst <= '0;
            r_rsp_err  <= 1'b0;
            r_rom_addr <= '0;
        end else if (w_accept) begin
            r_state    <= ARB_RESP;
            r_owner    <= w_grant;
            r_rsp_inst <= w_win_mis ? '0 : rom_inst;
            r_rsp_err  <= w_win_mis;
            r_rom_addr <= w_win_addr;
        end else if ((r_state == ARB_RESP) && w_owner_rdy) begin
            r_state <= ARB_IDLE;
        end
    end

    assign m0_rsp_valid = (r_state == ARB_RESP) && !r_owner;
    assign m1_rsp_valid = (r_state == ARB_RESP) && r_owner;
    assign m0_rsp_inst  = m0_rsp_valid ? r_rsp_inst : '0;
    assign m1_rsp_inst  = m1_rsp_valid ? r_rsp_inst : '0;
    assign m0_rsp_err   = m0_rsp_valid && r_rsp_err;
    assign m1_rsp_err   = m1_rsp_valid && r_rsp_err;

endmodule

// File: doc/ysyx_2022040010_inst_fetch_arb.md
Name: ysyx_2022040010_inst_fetch_arb

Overview:
- Shares the single combinational instruction ROM port between two requesters.
  - Requester 0 is the core IF stage.
  - Requester 1 is the debug/loader port, used for difftest readback and memory dumps.
- Performs valid/ready request arbitration and drives ROM ce/addr.
- Registers the ROM word into a per-transaction response slot, returned to the winner with valid/ready backpressure.
- Sits between the IF stage and the ROM; one outstanding transaction at a time, sustaining one fetch per cycle when responses are consumed immediately.

Parameters:
- ADDR_W, 64, instruction address width (matches InstAddrBus).
- INST_W, 32, instruction width (matches InstBus).
- MAX_CORE_RUN, 4, maximum consecutive core grants while requester 1 is waiting (range 1..15).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req_valid  in  1  core fetch request.
- m0_req_addr  in  ADDR_W  core byte address.
- m0_req_ready  out  1  core request accepted this cycle.
- m0_rsp_valid  out  1  core response available.
- m0_rsp_inst  out  INST_W  fetched word.
- m0_rsp_err  out  1  misaligned-address error.
- m0_rsp_ready  in  1  core consumes response.
- m1_req_valid, m1_req_addr, m1_req_ready, m1_rsp_valid, m1_rsp_inst, m1_rsp_err, m1_rsp_ready: same as m0_*, for the debug port.
- rom_ce  out  1  ROM chip enable (ChipEnable/ChipDisable encoding).
- rom_addr  out  ADDR_W  ROM byte address.
- rom_inst  in  INST_W  combinational ROM data.

Behaviour:
- Reset (rst low, asynchronous): FSM to IDLE.
  - All rsp_valid low; rsp_inst = ZeroWord; rsp_err = 0.
  - Starvation counter = 0.
  - rom_ce = ChipDisable; rom_addr = 0.
- FSM has two states:
  - IDLE: no response held.
  - RESP: response held for owner (1 owner bit).
- can_accept = (state==IDLE) | (state==RESP & owner's rsp_valid & owner's rsp_ready).
- Grant is evaluated only when can_accept holds:
  - Only one requester valid: that requester wins.
  - Both valid: m0 wins unless run_cnt == MAX_CORE_RUN, in which case m1 wins.
- mN_req_ready = can_accept & grant==N. Ready may depend combinationally on valid; valid must not depend on ready.
- Accept cycle:
  - rom_ce = ChipEnable; rom_addr = winner addr.
  - On the edge: rsp_inst <= rom_inst, owner <= winner, state <= RESP, winner rsp_valid = 1.
  - Latency: request accepted in cycle N, response valid in N+1.
- Misaligned address (addr[1:0] != 0):
  - Still accepted.
  - rom_ce stays ChipDisable for that cycle.
  - Response is rsp_err = 1, rsp_inst = ZeroWord.
- No accept cycle: rom_ce = ChipDisable; rom_addr holds its previous value (registered mux select, no X).
- Response hold rules:
  - rsp_inst and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
  - Only the owner's rsp_valid is ever high; the other port reads valid=0, inst=ZeroWord.
- Response completes without a new accept: state returns to IDLE.
- Response completes together with a new accept (same cycle): state stays RESP with the new owner/data. Back-to-back throughput is 1/cycle.
- run_cnt update:
  - m0 granted while m1_req_valid = 1: +1, saturating at MAX_CORE_RUN.
  - m1 granted, or m1_req_valid = 0: reset to 0.
- Reset asserted mid-transaction: held response is dropped with no completion; requesters must reissue.
- Address width: rom_addr passes the full byte address. Word indexing ([log2+1:2]) is the ROM's job.

Decomposition:
- Shared package / defines.v additions:
  - FSM state encodings ARB_IDLE, ARB_RESP.
  - MAX_CORE_RUN default.
  - Existing ChipEnable/ChipDisable/ZeroWord, InstAddrBus, InstBus.
- One natural sub-module: ysyx_2022040010_rr_starve_cnt, the starvation counter plus grant decision, with combinational grant out and registered counter.
- Response slot and FSM remain in the top module.

Test Plan:
- Single fetch: m0 req addr 0x8000_0000 with ROM word 0x0000_0413 -> m0_req_ready same cycle, m0_rsp_valid next cycle, inst 0x00000413, err 0.
- Streaming: m0 valid 8 consecutive cycles with rsp_ready tied 1, addrs +4 -> 8 responses on 8 consecutive cycles, in order.
- Backpressure: m0_rsp_ready = 0 for 3 cycles -> rsp_inst stable, m0_req_ready = 0, rom_ce disabled; release -> completion plus new accept in the same cycle.
- Fairness with MAX_CORE_RUN = 4, both valid continuously -> grant pattern m0,m0,m0,m0,m1, repeating.
- Misaligned: m1 addr 0x8000_0002 -> rom_ce never enabled, m1_rsp_err = 1, inst = 0.
- Reset while m1_rsp_valid = 1 -> all rsp_valid low immediately (asynchronous); first post-reset request is served normally.
